// File: rtl/comm_arb_rr.sv
// comm_arb_rr: nIN-to-nOUT pipelined commutator with a hold register per input,
// per-output round-robin arbitration, valid/ready on both sides and saturating status counters.
module comm_arb_rr #(
  parameter int nIN  = 8,
  parameter int nOUT = 13,
  parameter int wD   = 25,
  parameter int wCNT = 16,
  localparam int wA  = $clog2(nOUT),
  localparam int wI  = $clog2(nIN)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [nIN-1:0]       in_valid,
  output logic [nIN-1:0]       in_ready,
  input  logic [nIN*wD-1:0]    data_in,
  input  logic [nIN*wA-1:0]    addr_in,
  output logic [nOUT-1:0]      out_valid,
  input  logic [nOUT-1:0]      out_ready,
  output logic [nOUT*wD-1:0]   data_out,
  output logic [nOUT*wI-1:0]   src_out,
  output logic [wCNT-1:0]      stall_cnt,
  output logic [wCNT-1:0]      err_cnt
);

  localparam logic [wA:0]     N_OUT_W = (wA+1)'(nOUT);
  localparam logic [wCNT-1:0] CNT_MAX = '1;

  function automatic logic [wI-1:0] wrap_add(input logic [wI-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    return (sum >= nIN) ? wI'(sum - nIN) : wI'(sum);
  endfunction

  function automatic logic addr_ok(input logic [wA-1:0] a);
    return ({1'b0, a} < N_OUT_W);
  endfunction

  logic [nIN-1:0]  hv_r;
  logic [wD-1:0]   hd_r [nIN];
  logic [wA-1:0]   ha_r [nIN];
  logic [nOUT-1:0] ov_r;
  logic [wD-1:0]   od_r [nOUT];
  logic [wI-1:0]   os_r [nOUT];
  logic [wI-1:0]   ptr_r [nOUT];
  logic [wCNT-1:0] stall_r;
  logic [wCNT-1:0] err_r;

  logic [nOUT-1:0] slot_free_s;
  logic [nOUT-1:0] gnt_vld_s;
  logic [wI-1:0]   gnt_idx_s [nOUT];
  logic [wI-1:0]   cand_s;
  logic            hit_s;
  logic [nIN-1:0]  granted_s;
  logic [nIN-1:0]  bad_s;
  logic [nIN-1:0]  leave_s;
  logic            stall_inc_s;

  assign slot_free_s = ~ov_r | out_ready;

  // Round-robin search per output; descending scan so the lowest offset from ptr wins
  always_comb begin
    gnt_vld_s = '0;
    cand_s    = '0;
    hit_s     = 1'b0;
    for (int o = 0; o < nOUT; o++) begin
      gnt_idx_s[o] = '0;
      for (int j = nIN - 1; j >= 0; j--) begin
        cand_s       = wrap_add(ptr_r[o], j);
        hit_s        = slot_free_s[o] & hv_r[cand_s] & (ha_r[cand_s] == wA'(o));
        gnt_vld_s[o] = gnt_vld_s[o] | hit_s;
        gnt_idx_s[o] = hit_s ? cand_s : gnt_idx_s[o];
      end
    end
  end

  // Fold per-output grants back onto the inputs and flag held words with bad addresses
  always_comb begin
    granted_s = '0;
    bad_s     = '0;
    for (int o = 0; o < nOUT; o++) begin
      granted_s[gnt_idx_s[o]] = granted_s[gnt_idx_s[o]] | gnt_vld_s[o];
    end
    for (int i = 0; i < nIN; i++) begin
      bad_s[i] = hv_r[i] & ~addr_ok(ha_r[i]);
    end
  end

  // out_ready reaches in_ready combinationally through the grant so a channel can stream
  assign leave_s     = granted_s | bad_s;
  assign in_ready    = ~hv_r | leave_s;
  assign stall_inc_s = |(hv_r & ~bad_s & ~granted_s);

  // Input hold registers: capture on handshake, otherwise release when granted or dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hv_r <= '0;
      for (int i = 0; i < nIN; i++) begin
        hd_r[i] <= '0;
        ha_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < nIN; i++) begin
        if (in_valid[i] && in_ready[i]) begin
          hv_r[i] <= 1'b1;
          hd_r[i] <= data_in[i*wD +: wD];
          ha_r[i] <= addr_in[i*wA +: wA];
        end else if (leave_s[i]) begin
          hv_r[i] <= 1'b0;
        end else begin
          hv_r[i] <= hv_r[i];
        end
      end
    end
  end

  // Output registers and round-robin pointers; payload only changes on a grant
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ov_r <= '0;
      for (int o = 0; o < nOUT; o++) begin
        od_r[o]  <= '0;
        os_r[o]  <= '0;
        ptr_r[o] <= '0;
      end
    end else begin
      for (int o = 0; o < nOUT; o++) begin
        if (gnt_vld_s[o]) begin
          ov_r[o]  <= 1'b1;
          od_r[o]  <= hd_r[gnt_idx_s[o]];
          os_r[o]  <= gnt_idx_s[o];
          ptr_r[o] <= wrap_add(gnt_idx_s[o], 1);
        end else if (out_ready[o]) begin
          ov_r[o]  <= 1'b0;
        end else begin
          ov_r[o]  <= ov_r[o];
        end
      end
    end
  end

  // Saturating status counters; several drops in one cycle count once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_r <= '0;
      err_r   <= '0;
    end else begin
      stall_r <= (stall_inc_s && (stall_r != CNT_MAX)) ? stall_r + wCNT'(1) : stall_r;
      err_r   <= ((|bad_s) && (err_r != CNT_MAX)) ? err_r + wCNT'(1) : err_r;
    end
  end

  for (genvar o = 0; o < nOUT; o++) begin : g_out
    assign data_out[o*wD +: wD] = od_r[o];
    assign src_out[o*wI +: wI]  = os_r[o];
  end

  assign out_valid = ov_r;
  assign stall_cnt = stall_r;
  assign err_cnt   = err_r;

endmodule

// File: tb/tb_comm_arb_rr.sv
// Self-checking bench for comm_arb_rr: directed scenarios plus randomized traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_comm_arb_rr;
  localparam int N_IN = 8, N_OUT = 13, W_D = 25, W_A = 4, W_I = 3, W_C = 16;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [N_IN-1:0]        in_valid;
  logic [N_IN-1:0]        in_ready;
  logic [N_IN*W_D-1:0]    data_in;
  logic [N_IN*W_A-1:0]    addr_in;
  logic [N_OUT-1:0]       out_valid;
  logic [N_OUT-1:0]       out_ready;
  logic [N_OUT*W_D-1:0]   data_out;
  logic [N_OUT*W_I-1:0]   src_out;
  logic [W_C-1:0]         stall_cnt;
  logic [W_C-1:0]         err_cnt;

  int total = 0;
  int bad = 0;

  comm_arb_rr #(.nIN(N_IN), .nOUT(N_OUT), .wD(W_D), .wCNT(W_C)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .addr_in(addr_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .src_out(src_out), .stall_cnt(stall_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state: held words per input, output slots, pointers, counters
  bit  m_hv [N_IN];
  int  m_hd [N_IN];
  int  m_ha [N_IN];
  bit  m_ov [N_OUT];
  int  m_od [N_OUT];
  int  m_os [N_OUT];
  int  m_ptr [N_OUT];
  int  m_stall, m_err;
  bit  m_gv [N_OUT];
  int  m_gi [N_OUT];
  bit  m_gnt [N_IN];
  bit  m_bad [N_IN];
  logic [N_IN-1:0] m_rdy;
  logic [N_IN-1:0] obs_rdy;
  logic [N_OUT-1:0]     e_v;
  logic [N_OUT*W_D-1:0] e_d;
  logic [N_OUT*W_I-1:0] e_s;

  task automatic model_reset();
    for (int i = 0; i < N_IN; i++) begin m_hv[i] = 0; m_hd[i] = 0; m_ha[i] = 0; end
    for (int o = 0; o < N_OUT; o++) begin m_ov[o] = 0; m_od[o] = 0; m_os[o] = 0; m_ptr[o] = 0; end
    m_stall = 0;
    m_err = 0;
  endtask

  task automatic model_comb();
    int k;
    for (int i = 0; i < N_IN; i++) m_gnt[i] = 0;
    for (int o = 0; o < N_OUT; o++) begin
      m_gv[o] = 0;
      m_gi[o] = 0;
      if (!m_ov[o] || out_ready[o]) begin
        for (int j = 0; j < N_IN; j++) begin
          k = (m_ptr[o] + j) % N_IN;
          if (!m_gv[o] && m_hv[k] && m_ha[k] == o) begin
            m_gv[o] = 1; m_gi[o] = k; m_gnt[k] = 1;
          end
        end
      end
    end
    for (int i = 0; i < N_IN; i++) begin
      m_bad[i] = m_hv[i] && (m_ha[i] >= N_OUT);
      m_rdy[i] = !m_hv[i] || m_gnt[i] || m_bad[i];
    end
  endtask

  task automatic model_seq();
    bit st, er;
    st = 0;
    er = 0;
    for (int i = 0; i < N_IN; i++) begin
      if (m_hv[i] && m_ha[i] < N_OUT && !m_gnt[i]) st = 1;
      if (m_bad[i]) er = 1;
    end
    for (int o = 0; o < N_OUT; o++) begin
      if (m_gv[o]) begin
        m_od[o] = m_hd[m_gi[o]]; m_os[o] = m_gi[o]; m_ov[o] = 1;
        m_ptr[o] = (m_gi[o] + 1) % N_IN;
      end else if (out_ready[o]) m_ov[o] = 0;
    end
    for (int i = 0; i < N_IN; i++) begin
      if (in_valid[i] && m_rdy[i]) begin
        m_hv[i] = 1;
        m_hd[i] = int'(data_in[i*W_D +: W_D]);
        m_ha[i] = int'(addr_in[i*W_A +: W_A]);
      end else if (m_gnt[i] || m_bad[i]) m_hv[i] = 0;
    end
    if (st && m_stall < 65535) m_stall++;
    if (er && m_err < 65535) m_err++;
  endtask

  // One clock: inputs were set at the previous falling edge; returns at the next one
  task automatic cycle();
    #1;
    model_comb();
    obs_rdy = in_ready;
    @(posedge clk);
    model_seq();
    @(negedge clk);
  endtask

  task automatic drive_word(input int i, input int d, input int a);
    in_valid[i] = 1'b1;
    data_in[i*W_D +: W_D] = W_D'(d);
    addr_in[i*W_A +: W_A] = W_A'(a);
  endtask

  task automatic idle();
    in_valid = '0;
  endtask

  task automatic test_reset();
    total++; if (out_valid !== 13'h0) begin bad++; $display("FAIL reset_out_valid got=%h exp=0", out_valid); end
    total++; if (in_ready !== 8'hFF) begin bad++; $display("FAIL reset_in_ready got=%h exp=ff", in_ready); end
    total++; if (data_out !== '0) begin bad++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
    total++; if (src_out !== '0) begin bad++; $display("FAIL reset_src_out got=%h exp=0", src_out); end
    total++; if (stall_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cnt, err_cnt);
    end
  endtask

  task automatic test_single_path();
    out_ready = '1;
    idle();
    drive_word(0, 25'h1ABCDEF, 5);
    cycle();
    total++; if (obs_rdy[0] !== 1'b1) begin bad++; $display("FAIL single_ready got=%b exp=1", obs_rdy[0]); end
    idle();
    total++; if (out_valid !== 13'h0) begin bad++; $display("FAIL single_early got=%h exp=0", out_valid); end
    cycle();
    total++; if (out_valid !== 13'h0020) begin bad++; $display("FAIL single_valid got=%h exp=0020", out_valid); end
    total++; if (data_out[5*W_D +: W_D] !== 25'h1ABCDEF) begin
      bad++; $display("FAIL single_data got=%h exp=1abcdef", data_out[5*W_D +: W_D]);
    end
    total++; if (src_out[5*W_I +: W_I] !== 3'd0) begin bad++; $display("FAIL single_src got=%0d exp=0", src_out[5*W_I +: W_I]); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL single_stall got=%0d exp=0", stall_cnt); end
    cycle();
    total++; if (out_valid !== 13'h0) begin bad++; $display("FAIL single_clear got=%h exp=0", out_valid); end
  endtask

  task automatic test_collision();
    int exp_src [3];
    exp_src[0] = 1; exp_src[1] = 3; exp_src[2] = 6;
    idle();
    drive_word(1, 25'h0000111, 2);
    drive_word(3, 25'h0000333, 2);
    drive_word(6, 25'h0000666, 2);
    cycle();
    idle();
    for (int n = 0; n < 3; n++) begin
      cycle();
      if (n == 0) begin
        total++; if (obs_rdy[1] !== 1'b1 || obs_rdy[3] !== 1'b0 || obs_rdy[6] !== 1'b0) begin
          bad++; $display("FAIL coll_ready0 got=%b exp=1,0,0", {obs_rdy[1], obs_rdy[3], obs_rdy[6]});
        end
      end
      if (n == 1) begin
        total++; if (obs_rdy[6] !== 1'b0) begin bad++; $display("FAIL coll_ready1 got=%b exp=0", obs_rdy[6]); end
      end
      total++; if (out_valid[2] !== 1'b1 || int'(src_out[2*W_I +: W_I]) != exp_src[n]) begin
        bad++; $display("FAIL coll_src%0d got=%b/%0d exp=1/%0d", n, out_valid[2], src_out[2*W_I +: W_I], exp_src[n]);
      end
      total++; if (int'(data_out[2*W_D +: W_D]) != ('h111 * exp_src[n])) begin
        bad++; $display("FAIL coll_data%0d got=%h exp=%h", n, data_out[2*W_D +: W_D], 'h111 * exp_src[n]);
      end
    end
    cycle();
    total++; if (out_valid !== 13'h0) begin bad++; $display("FAIL coll_drain got=%h exp=0", out_valid); end
    total++; if (stall_cnt !== 16'd2) begin bad++; $display("FAIL coll_stall got=%0d exp=2", stall_cnt); end
  endtask

  task automatic test_bad_addr();
    idle();
    drive_word(5, 25'h0055555, 14);
    cycle();
    idle();
    total++; if (out_valid !== 13'h0) begin bad++; $display("FAIL bad_out0 got=%h exp=0", out_valid); end
    cycle();
    total++; if (obs_rdy[5] !== 1'b1) begin bad++; $display("FAIL bad_ready got=%b exp=1", obs_rdy[5]); end
    total++; if (out_valid !== 13'h0) begin bad++; $display("FAIL bad_out1 got=%h exp=0", out_valid); end
    total++; if (err_cnt !== 16'd1) begin bad++; $display("FAIL bad_err got=%0d exp=1", err_cnt); end
    total++; if (stall_cnt !== 16'd2) begin bad++; $display("FAIL bad_stall got=%0d exp=2", stall_cnt); end
  endtask

  task automatic test_fairness();
    int seq0, seq4, exp0, exp4, cnt0, cnt4, got, prev, src, d;
    seq0 = 0; seq4 = 0; exp0 = 0; exp4 = 0; cnt0 = 0; cnt4 = 0; got = 0; prev = -1;
    idle();
    out_ready = '1;
    for (int c = 0; c < 400 && got < 100; c++) begin
      drive_word(0, seq0, 7);
      drive_word(4, (1 << 20) | seq4, 7);
      cycle();
      if (obs_rdy[0]) seq0++;
      if (obs_rdy[4]) seq4++;
      if (out_valid[7]) begin
        src = int'(src_out[7*W_I +: W_I]);
        d   = int'(data_out[7*W_D +: W_D]);
        if (prev >= 0) begin
          total++; if (src == prev) begin bad++; $display("FAIL fair_alternate got=%0d exp=not %0d", src, prev); end
        end
        total++;
        if (src == 0) begin
          if (d != exp0) begin bad++; $display("FAIL fair_data0 got=%h exp=%h", d, exp0); end
          exp0++; cnt0++;
        end else if (src == 4) begin
          if (d != ((1 << 20) | exp4)) begin bad++; $display("FAIL fair_data4 got=%h exp=%h", d, (1 << 20) | exp4); end
          exp4++; cnt4++;
        end else begin
          bad++; $display("FAIL fair_src got=%0d exp=0 or 4", src);
        end
        prev = src;
        got++;
      end
    end
    idle();
    total++; if (got != 100) begin bad++; $display("FAIL fair_timeout got=%0d exp=100", got); end
    total++; if (cnt0 != 50 || cnt4 != 50) begin bad++; $display("FAIL fair_share got=%0d/%0d exp=50/50", cnt0, cnt4); end
    repeat (4) cycle();
  endtask

  task automatic test_backpressure();
    int sent, popped;
    int q[$];
    sent = 0; popped = 0;
    idle();
    out_ready = '1;
    for (int c = 0; c < 30; c++) begin
      out_ready[9] = (c >= 5);
      if (sent < 6) drive_word(2, 'h0900000 + sent, 9);
      else in_valid[2] = 1'b0;
      if (c >= 2 && c <= 4) begin
        total++; if (out_valid[9] !== 1'b1 || data_out[9*W_D +: W_D] !== 25'h0900000) begin
          bad++; $display("FAIL bp_hold got=%b/%h exp=1/0900000", out_valid[9], data_out[9*W_D +: W_D]);
        end
      end
      if (c >= 5 && c <= 10) begin
        total++; if (out_valid[9] !== 1'b1) begin bad++; $display("FAIL bp_stream c=%0d got=0 exp=1", c); end
      end
      if (out_valid[9] && out_ready[9]) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL bp_order got=%h exp=none", data_out[9*W_D +: W_D]);
        end else begin
          if (int'(data_out[9*W_D +: W_D]) != q[0] || src_out[9*W_I +: W_I] !== 3'd2) begin
            bad++; $display("FAIL bp_order got=%h/%0d exp=%h/2", data_out[9*W_D +: W_D], src_out[9*W_I +: W_I], q[0]);
          end
          void'(q.pop_front());
        end
        popped++;
      end
      cycle();
      if (c >= 2 && c <= 4) begin
        total++; if (obs_rdy[2] !== 1'b0) begin bad++; $display("FAIL bp_ready c=%0d got=1 exp=0", c); end
      end
      if (in_valid[2] && obs_rdy[2]) begin
        q.push_back('h0900000 + sent);
        sent++;
      end
    end
    idle();
    total++; if (popped != 6) begin bad++; $display("FAIL bp_count got=%0d exp=6", popped); end
  endtask

  task automatic test_async_reset();
    idle();
    out_ready = '1;
    drive_word(0, 25'h0000AAA, 3);
    drive_word(1, 25'h0000BBB, 3);
    cycle();
    cycle();
    total++; if (out_valid[3] !== 1'b1 || err_cnt !== 16'd1) begin
      bad++; $display("FAIL areset_pre got=%b/%0d exp=1/1", out_valid[3], err_cnt);
    end
    total++; if (int'(stall_cnt) != m_stall) begin bad++; $display("FAIL areset_prestall got=%0d exp=%0d", stall_cnt, m_stall); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (out_valid !== 13'h0) begin bad++; $display("FAIL areset_valid got=%h exp=0", out_valid); end
    total++; if (stall_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      bad++; $display("FAIL areset_cnt got=%0d/%0d exp=0/0", stall_cnt, err_cnt);
    end
    total++; if (in_ready !== 8'hFF) begin bad++; $display("FAIL areset_ready got=%h exp=ff", in_ready); end
    idle();
    model_reset();
    @(posedge clk);
    #1;
    total++; if (out_valid !== 13'h0) begin bad++; $display("FAIL areset_glitch got=%h exp=0", out_valid); end
    @(negedge clk);
    reset_n = 1'b1;
    drive_word(2, 25'h0ABCDE1, 11);
    cycle();
    idle();
    total++; if (out_valid !== 13'h0) begin bad++; $display("FAIL areset_early got=%h exp=0", out_valid); end
    cycle();
    total++; if (out_valid !== 13'h0800 || data_out[11*W_D +: W_D] !== 25'h0ABCDE1 || src_out[11*W_I +: W_I] !== 3'd2) begin
      bad++; $display("FAIL areset_route got=%h/%h/%0d exp=0800/0abcde1/2", out_valid, data_out[11*W_D +: W_D], src_out[11*W_I +: W_I]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N_IN; i++) begin
        if ($urandom_range(0, 1) == 1)
          drive_word(i, int'($urandom_range(0, 33554431)),
                     ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 15)) : int'($urandom_range(0, 12)));
        else in_valid[i] = 1'b0;
      end
      for (int o = 0; o < N_OUT; o++) out_ready[o] = ($urandom_range(0, 3) != 0);
      cycle();
      for (int o = 0; o < N_OUT; o++) begin
        e_v[o] = m_ov[o];
        e_d[o*W_D +: W_D] = W_D'(m_od[o]);
        e_s[o*W_I +: W_I] = W_I'(m_os[o]);
      end
      total++; if (obs_rdy !== m_rdy) begin bad++; $display("FAIL rnd_in_ready c=%0d got=%h exp=%h", c, obs_rdy, m_rdy); end
      total++; if (out_valid !== e_v) begin bad++; $display("FAIL rnd_out_valid c=%0d got=%h exp=%h", c, out_valid, e_v); end
      total++; if (data_out !== e_d) begin bad++; $display("FAIL rnd_data_out c=%0d got=%h exp=%h", c, data_out, e_d); end
      total++; if (src_out !== e_s) begin bad++; $display("FAIL rnd_src_out c=%0d got=%h exp=%h", c, src_out, e_s); end
      total++; if (int'(stall_cnt) != m_stall || int'(err_cnt) != m_err) begin
        bad++; $display("FAIL rnd_counters c=%0d got=%0d/%0d exp=%0d/%0d", c, stall_cnt, err_cnt, m_stall, m_err);
      end
    end
    idle();
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = '0;
    data_in   = '0;
    addr_in   = '0;
    out_ready = '1;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_single_path();
    test_collision();
    test_bad_addr();
    test_fairness();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
